mem_stream_cntrl: RTL
=====================

Name: mem_stream_cntrl

Overview:
Parametrised successor to the single-port init-then-read memory controller.
- After reset, clears every RAM word to CLEAR_VAL, then runs the same storage as a streaming FIFO with valid/ready handshakes on both sides.
- Sits between a producer datapath and a consumer in the negedge-clocked design tops.
- Adds over the previous generation: generic width/depth, a clear value, back-pressure, occupancy reporting and an init-done status.

Parameters:
WIDTH, 32, data word width in bits
ADDR, 10, address width; DEPTH = 2**ADDR words
CLEAR_VAL, 0, value written to every word during init (WIDTH bits)

Ports:
clk  input  1  clock; all state updates on the falling edge
rst  input  1  synchronous active-high reset, sampled on the falling edge of clk
in_valid  input  1  producer presents in_data
in_ready  output  1  controller accepts in_data this cycle
in_data  input  WIDTH  write data
out_valid  output  1  out_data holds a valid word
out_ready  input  1  consumer takes out_data this cycle
out_data  output  WIDTH  read data (registered)
init_done  output  1  clear sequence complete
level  output  ADDR+1  words accepted and not yet popped, range 0..DEPTH

Behaviour:
- Reset (rst=1 at a falling edge):
  - state<=INIT; clr_addr, wr_ptr, rd_ptr <= 0.
  - level<=0, out_valid<=0, out_data<=0, init_done<=0.
  - in_ready is combinational and is 0 while rst=1.
- Mid-operation reset: same as above. All queued data is discarded, and the whole RAM is cleared again.
- INIT:
  - Writes CLEAR_VAL to clr_addr on each edge; clr_addr increments.
  - The edge that writes address DEPTH-1 moves state to RUN and sets init_done<=1.
  - INIT therefore lasts exactly DEPTH edges after reset deasserts.
  - in_ready=0 and out_valid=0 throughout; in_valid and out_ready are ignored.
- RUN:
  - in_ready = (level < DEPTH).
  - Push when in_valid & in_ready: RAM[wr_ptr]<=in_data, and wr_ptr wraps modulo DEPTH.
  - Pop when out_valid & out_ready.
  - Output register (show-ahead):
    - When out_valid=0, or a pop occurs, and the RAM holds unread words, the controller reads RAM[rd_ptr] into out_data, sets out_valid<=1 and advances rd_ptr (wrap modulo DEPTH).
    - When a pop occurs and the RAM holds no unread words, out_valid<=0 and out_data holds its old value.
  - Read latency: a word pushed at edge N into an empty controller shows out_valid=1 after edge N+1. There is no same-cycle bypass.
  - level:
    - +1 on push only, -1 on pop only, unchanged on simultaneous push and pop.
    - Push is blocked when level=DEPTH, so no overflow.
    - Pop cannot occur when out_valid=0, so no underflow.
  - Read/write collision: the read address never equals the write address on the same edge, because reads only occur on unread words and writes are blocked at full. The RAM needs no read-during-write rule.
- Pointers are ADDR bits wide and wrap naturally. level is computed separately, with ADDR+1 bits.

Optional Feature:
MEM_STREAM_PARITY_EN.
- Defined:
  - RAM width becomes WIDTH+1, storing even parity of in_data; CLEAR_VAL is stored with its matching parity.
  - On every load of the output register, parity is rechecked.
  - A mismatch sets the sticky output parity_err (1 bit, added port), which only rst clears.
- Undefined: no parity bit, no parity_err port, and RAM width is WIDTH.

Decomposition:
- Shared package mem_stream_pkg: state encoding (INIT=1'b0, RUN=1'b1), a parity function, and a DEPTH-from-ADDR helper constant.
- One sub-module: mem_stream_sdp_ram, a simple dual-port RAM.
  - Falling-edge write: wr_en, wr_addr, wr_data.
  - Falling-edge synchronous read: rd_en, rd_addr, rd_data.
  - No reset on the array.

Test Plan:
- Clear check, ADDR=4, CLEAR_VAL=32'hA5A5A5A5:
  - rst for 3 edges, then release → init_done rises after exactly 16 edges; in_ready=0 until then.
  - Backdoor read of all 16 words = A5A5A5A5.
- Single word: push 32'h1234 into an empty FIFO at edge N → out_valid=1 and out_data=32'h1234 after edge N+1; level=1; after pop, level=0 and out_valid=0.
- Full/back-pressure, ADDR=4:
  - Push 20 words with out_ready=0 → exactly 16 accepted, level=16, in_ready=0.
  - Drain → values 0..15 in order; level returns to 0.
- Streaming with wrap: in_valid=out_ready=1 continuously for 100 words, ADDR=4 → output equals input order; level stays ≤2; pointers wrap cleanly.
- Reset mid-stream: assert rst with level=7 → next edge: out_valid=0, level=0, init_done=0; full clear repeats; previously queued data never appears.
- Parity (MEM_STREAM_PARITY_EN): force-flip one stored bit via backdoor, then pop that word → parity_err=1 and it stays 1 until rst.

Source files
------------

// File: rtl/mem_stream_pkg.sv
// Shared types and helpers for the clear-then-stream memory controller.
package mem_stream_pkg;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam int PAR_MAX_W = 256;

  function automatic int depth_of(input int addr);
    return 1 << addr;
  endfunction

  // Even parity bit: data plus this bit always holds an even number of ones.
  function automatic logic even_par(input logic [PAR_MAX_W-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/mem_stream_sdp_ram.sv
// Simple dual-port RAM, falling-edge write and registered falling-edge read.
module mem_stream_sdp_ram #(
  parameter int W = 32,
  parameter int A = 10
) (
  input  logic         clk,
  input  logic         wr_en,
  input  logic [A-1:0] wr_addr,
  input  logic [W-1:0] wr_data,
  input  logic         rd_en,
  input  logic [A-1:0] rd_addr,
  output logic [W-1:0] rd_data
);

  logic [W-1:0] mem [2**A];
  logic [W-1:0] rd_data_q;

  always_ff @(negedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data_q <= mem[rd_addr];
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/mem_stream_cntrl.sv
// Clears the RAM to CLEAR_VAL after reset, then runs it as a show-ahead FIFO.
// Define MEM_STREAM_PARITY_EN to store a parity bit per word and flag errors.
module mem_stream_cntrl
  import mem_stream_pkg::*;
#(
  parameter int               WIDTH     = 32,
  parameter int               ADDR      = 10,
  parameter logic [WIDTH-1:0] CLEAR_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             init_done,
  output logic [ADDR:0]    level
`ifdef MEM_STREAM_PARITY_EN
  ,output logic            parity_err
`endif
);

`ifdef MEM_STREAM_PARITY_EN
  localparam int PW = 1;
`else
  localparam int PW = 0;
`endif
  localparam int MW = WIDTH + PW;

  state_e            state_q, state_d;
  logic [ADDR-1:0]   clr_addr_q, clr_addr_d;
  logic [ADDR-1:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR-1:0]   rd_ptr_q, rd_ptr_d;
  logic [ADDR:0]     level_q, level_d;
  logic              out_valid_q, out_valid_d;
  logic              init_done_q, init_done_d;
  logic              loaded_q, loaded_d;

  logic              push, pop, load, ram_has;
  logic              wr_en;
  logic [ADDR-1:0]   wr_addr;
  logic [MW-1:0]     wr_data, rd_data;

  assign in_ready = !rst && (state_q == RUN) && !level_q[ADDR];
  assign push     = in_valid && in_ready;
  assign pop      = out_valid_q && out_ready;
  // Unread RAM words are those counted in level but not sitting in the output register.
  assign ram_has  = level_q != {{ADDR{1'b0}}, out_valid_q};
  assign load     = !rst && (state_q == RUN) && (!out_valid_q || pop) && ram_has;

  assign wr_en   = !rst && ((state_q == INIT) || push);
  assign wr_addr = (state_q == INIT) ? clr_addr_q : wr_ptr_q;
`ifdef MEM_STREAM_PARITY_EN
  assign wr_data = (state_q == INIT) ? {even_par(PAR_MAX_W'(CLEAR_VAL)), CLEAR_VAL}
                                     : {even_par(PAR_MAX_W'(in_data)), in_data};
`else
  assign wr_data = (state_q == INIT) ? CLEAR_VAL : in_data;
`endif

  mem_stream_sdp_ram #(.W(MW), .A(ADDR)) u_ram (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_en   (load),
    .rd_addr (rd_ptr_q),
    .rd_data (rd_data)
  );

  always_comb begin
    state_d     = state_q;
    clr_addr_d  = clr_addr_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    level_d     = level_q;
    out_valid_d = out_valid_q;
    init_done_d = init_done_q;
    loaded_d    = loaded_q;
    if (rst) begin
      state_d     = INIT;
      clr_addr_d  = '0;
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      level_d     = '0;
      out_valid_d = 1'b0;
      init_done_d = 1'b0;
      loaded_d    = 1'b0;
    end else if (state_q == INIT) begin
      clr_addr_d = clr_addr_q + 1'b1;
      if (&clr_addr_q) begin
        state_d     = RUN;
        init_done_d = 1'b1;
      end
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (load) begin
        rd_ptr_d    = rd_ptr_q + 1'b1;
        out_valid_d = 1'b1;
        loaded_d    = 1'b1;
      end else if (pop) begin
        out_valid_d = 1'b0;
      end
      case ({push, pop})
        2'b10:   level_d = level_q + 1'b1;
        2'b01:   level_d = level_q - 1'b1;
        default: level_d = level_q;
      endcase
    end
  end

  always_ff @(negedge clk) begin
    state_q     <= state_d;
    clr_addr_q  <= clr_addr_d;
    wr_ptr_q    <= wr_ptr_d;
    rd_ptr_q    <= rd_ptr_d;
    level_q     <= level_d;
    out_valid_q <= out_valid_d;
    init_done_q <= init_done_d;
    loaded_q    <= loaded_d;
  end

`ifdef MEM_STREAM_PARITY_EN
  logic chk_q, chk_d;
  logic perr_q, perr_d;

  // The RAM output settles one edge after a load, so the check lags by one edge.
  always_comb begin
    chk_d  = load;
    perr_d = perr_q | (chk_q & (^rd_data));
    if (rst) begin
      chk_d  = 1'b0;
      perr_d = 1'b0;
    end
  end

  always_ff @(negedge clk) begin
    chk_q  <= chk_d;
    perr_q <= perr_d;
  end

  assign parity_err = perr_q;
`endif

  // Until the first load after reset the RAM read register is stale, so show zero.
  assign out_data  = loaded_q ? rd_data[WIDTH-1:0] : '0;
  assign out_valid = out_valid_q;
  assign init_done = init_done_q;
  assign level     = level_q;

endmodule
